// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer and HI/LO register pair.
// The product is registered at capture and committed after MULT_CYCLES cycles.
// Division is a WIDTH-iteration restoring divider on magnitudes, with the signs
// corrected at commit. MTHI/MTLO writes override a same-edge result write.
// Optional build macro HILO_BYPASS_EN: hi_o/lo_o forward hilo_wdata during a write.
//
// state  | meaning
// IDLE   | waiting for an op; stalls the pipeline while op_valid is high
// MULT   | product held, latency counter running
// DIV    | one restoring quotient bit per cycle
// DONE   | result committed, one cycle without stall
module hilo_muldiv_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_type,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = ($clog2(WIDTH) > 4) ? $clog2(WIDTH) : 4;
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem, quo, dvsr;
  logic               neg_q, neg_r;

  logic               is_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] prod_signed, prod_unsigned;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt, q_fix, r_fix;

  // Operand conditioning: magnitudes for divide, full-width products for multiply.
  assign is_signed     = ~op_type[0];
  assign a_abs         = (is_signed && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
  assign b_abs         = (is_signed && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;
  assign prod_signed   = $signed({{WIDTH{src_a[WIDTH-1]}}, src_a}) *
                         $signed({{WIDTH{src_b[WIDTH-1]}}, src_b});
  assign prod_unsigned = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

  // One restoring step; trial[WIDTH] set means the subtraction borrowed.
  always_comb begin
    trial = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
    // Most-negative / -1 needs no special case: the magnitude quotient
    // 2^(WIDTH-1) negates back to itself.
    q_fix = neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
    r_fix = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;
  end

  // Control FSM, datapath registers and HI/LO; MT writes are placed last so they win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      prod  <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      if (flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (op_valid) begin
              cnt <= '0;
              if (!op_type[1]) begin
                prod  <= op_type[0] ? prod_unsigned : prod_signed;
                state <= S_MULT;
              end else if (src_b != '0) begin
                rem   <= '0;
                quo   <= a_abs;
                dvsr  <= b_abs;
                neg_q <= is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_r <= is_signed & src_a[WIDTH-1];
                state <= S_DIV;
              end else begin
                hi_r  <= src_a;
                lo_r  <= '1;
                state <= S_DONE;
              end
            end
          end
          S_MULT: begin
            if (cnt == MULT_LAST) begin
              hi_r  <= prod[2*WIDTH-1:WIDTH];
              lo_r  <= prod[WIDTH-1:0];
              cnt   <= '0;
              state <= S_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_DIV: begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (cnt == DIV_LAST) begin
              hi_r  <= r_fix;
              lo_r  <= q_fix;
              cnt   <= '0;
              state <= S_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
      if (hi_we) hi_r <= hilo_wdata;
      if (lo_we) lo_r <= hilo_wdata;
    end
  end

  // Pipeline hold and activity flags.
  assign stall_o = !flush && ((state == S_IDLE && op_valid) ||
                              state == S_MULT || state == S_DIV);
  assign busy_o  = (state != S_IDLE);

`ifdef HILO_BYPASS_EN
  // Same-cycle forwarding of MTHI/MTLO data to MFHI/MFLO.
  assign hi_o = hi_we ? hilo_wdata : hi_r;
  assign lo_o = lo_we ? hilo_wdata : lo_r;
`else
  // Register outputs only; a write becomes visible the following cycle.
  assign hi_o = hi_r;
  assign lo_o = lo_r;
`endif

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with hand-computed expectations.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] src_a, src_b;
  logic        flush, hi_we, lo_we;
  logic [31:0] hilo_wdata;
  logic        stall_o, busy_o;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_n;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  hilo_muldiv_ctrl #(.WIDTH(32), .MULT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
    .src_a(src_a), .src_b(src_b), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
    .hilo_wdata(hilo_wdata), .stall_o(stall_o), .busy_o(busy_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, count stall cycles (bounded), finish in the DONE cycle.
  task automatic do_op(input string tag, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] b, input int exp_stall);
    op_valid = 1'b1; op_type = t; src_a = a; src_b = b;
    #1;
    stall_n = 0;
    while (stall_o && stall_n < 100) begin
      stall_n++;
      tick();
      op_valid = 1'b0;
      #1;
    end
    check({tag, "_stall_cycles"}, 64'(stall_n), 64'(exp_stall));
    check({tag, "_busy_done"}, 64'(busy_o), 64'd1);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_type = 2'b00; src_a = '0; src_b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = '0;
    #1;
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_busy",  64'(busy_o),  64'd0);
    check("rst_hi",    64'(hi_o),    64'd0);
    check("rst_lo",    64'(lo_o),    64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // DIVU 100/7
    do_op("divu", OP_DIVU, 32'd100, 32'd7, 33);
    check("divu_lo", 64'(lo_o), 64'd14);
    check("divu_hi", 64'(hi_o), 64'd2);
    tick();
    check("divu_idle", 64'(busy_o), 64'd0);

    // DIV -7/2
    do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33);
    check("div_neg_lo", 64'(lo_o), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(hi_o), 64'hFFFF_FFFF);
    tick();

    // DIV most-negative / -1
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    check("div_ovf_lo", 64'(lo_o), 64'h8000_0000);
    check("div_ovf_hi", 64'(hi_o), 64'h0);
    tick();

    // MULT / MULTU -2*3 and 0xFFFFFFFE*3
    do_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 3);
    check("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo_o), 64'hFFFF_FFFA);
    tick();
    do_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 3);
    check("multu_hi", 64'(hi_o), 64'h2);
    check("multu_lo", 64'(lo_o), 64'hFFFF_FFFA);
    tick();

    // Divide by zero
    do_op("dvz", OP_DIVU, 32'h1234, 32'd0, 1);
    check("dvz_hi", 64'(hi_o), 64'h1234);
    check("dvz_lo", 64'(lo_o), 64'hFFFF_FFFF);
    tick();

    // Preload via MT, flush a DIVU at iteration 10
    hi_we = 1'b1; lo_we = 1'b1; hilo_wdata = 32'hAAAA;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    #1;
    check("mt_hi", 64'(hi_o), 64'hAAAA);
    check("mt_lo", 64'(lo_o), 64'hAAAA);
    op_valid = 1'b1; op_type = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    #1;
    check("flush_stall", 64'(stall_o), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_busy", 64'(busy_o), 64'd0);
    check("flush_hi", 64'(hi_o), 64'hAAAA);
    check("flush_lo", 64'(lo_o), 64'hAAAA);
    do_op("post_flush", OP_MULTU, 32'd3, 32'd4, 3);
    check("post_flush_lo", 64'(lo_o), 64'd12);
    check("post_flush_hi", 64'(hi_o), 64'd0);
    tick();

    // MTLO on the DIV completion edge
    op_valid = 1'b1; op_type = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    lo_we = 1'b1; hilo_wdata = 32'h55;
    tick();
    lo_we = 1'b0;
    #1;
    check("collide_busy", 64'(busy_o), 64'd1);
    check("collide_lo", 64'(lo_o), 64'h55);
    check("collide_hi", 64'(hi_o), 64'd2);
    tick();

    // MTHI visibility
    hi_we = 1'b1; hilo_wdata = 32'h77;
    #1;
`ifdef HILO_BYPASS_EN
    check("mthi_same_cycle", 64'(hi_o), 64'h77);
`else
    check("mthi_same_cycle", 64'(hi_o), 64'd2);
`endif
    tick();
    hi_we = 1'b0;
    #1;
    check("mthi_next_cycle", 64'(hi_o), 64'h77);

    // op_valid held through DONE must not retrigger
    op_valid = 1'b1; op_type = OP_DIVU; src_a = 32'h99; src_b = 32'd0;
    #1;
    check("hold_stall_t", 64'(stall_o), 64'd1);
    tick();
    check("hold_stall_done", 64'(stall_o), 64'd0);
    check("hold_busy_done", 64'(busy_o), 64'd1);
    op_valid = 1'b0;
    tick();
    check("hold_idle", 64'(busy_o), 64'd0);

    // flush beats op_valid in IDLE
    op_valid = 1'b1; op_type = OP_MULT; src_a = 32'd5; src_b = 32'd5; flush = 1'b1;
    #1;
    check("idle_flush_stall", 64'(stall_o), 64'd0);
    tick();
    op_valid = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush_busy", 64'(busy_o), 64'd0);
    check("idle_flush_lo", 64'(lo_o), 64'hFFFF_FFFF);

    // reset mid-operation
    op_valid = 1'b1; op_type = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_hi", 64'(hi_o), 64'd0);
    check("rst_mid_lo", 64'(lo_o), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Sequences multi-cycle MULT/MULTU/DIV/DIVU for the execute stage and owns the HI/LO register pair.
It accepts an operation from the decoder's hilo-write path and stalls the pipeline until the result is committed.
It also services MTHI/MTLO writes and supplies HI/LO to MFHI/MFLO.
It contains the iterative restoring divider, a registered multiplier with latency counter, and the control FSM.

Parameters:
WIDTH 32 operand width; HI and LO are WIDTH bits each.
MULT_CYCLES 2 cycles spent in MULT state; legal range 1..15.

Ports:
clk input 1 clock; all state updates on the rising edge.
rst input 1 reset; asynchronous, active-high.
op_valid input 1 mult/div instruction present in E stage.
op_type input 2 operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
src_a input WIDTH rs operand; dividend or multiplicand.
src_b input WIDTH rt operand; divisor or multiplier.
flush input 1 exception/pipeline flush; cancels the operation.
hi_we input 1 MTHI write enable.
lo_we input 1 MTLO write enable.
hilo_wdata input WIDTH MTHI/MTLO data.
stall_o output 1 holds F/D/E stages.
busy_o output 1 state is not IDLE.
hi_o output WIDTH HI register value.
lo_o output WIDTH LO register value.

Behaviour:
- Reset: state IDLE, HI=0, LO=0, counter=0, stall_o=0, busy_o=0.
- States and transitions:
  - IDLE -> MULT on op_valid with op_type[1]=0. The full 2*WIDTH product (signed or unsigned) is registered on the capture edge.
  - IDLE -> DIV on op_valid with op_type[1]=1 and src_b!=0. Capture stores |a| and |b| (signed) or a and b (unsigned), the sign of a, and the sign of a^b.
  - IDLE -> DONE on op_valid, divide, src_b==0. The capture edge writes HI=src_a, LO={WIDTH{1}}.
  - MULT: counter runs 0..MULT_CYCLES-1. The last edge writes HI=product[63:32], LO=product[31:0]; next state is DONE.
  - DIV: 32 restoring iterations, counter 0..31, one quotient bit per cycle. The last edge writes the sign-corrected result; next state is DONE.
    - Quotient is negated if the signs differ. Remainder takes the dividend's sign.
    - 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - DONE: exactly one cycle, no stall, then IDLE. op_valid is ignored here so the same instruction does not retrigger.
- stall_o = !flush && ((IDLE && op_valid) || MULT || DIV). It is combinational.
- Stall windows for an op captured at cycle t:
  - DIV: stall high cycles t..t+32, DONE at t+33.
  - MULT: stall high t..t+MULT_CYCLES.
  - Divide by zero: stall high only at t.
- busy_o = state!=IDLE.
- flush in any state: next state IDLE, counter cleared, no HI/LO result write, stall_o=0 in that cycle. flush has priority over op_valid and completion.
- MTHI/MTLO: hi_we/lo_we write hilo_wdata on the edge in any state. On a same-edge collision with a completion write, the MT write wins for its half; the other half takes the result.
- rst mid-operation: immediate return to reset values.

Optional Feature:
HILO_BYPASS_EN
- Defined: hi_o = hi_we ? hilo_wdata : HI, and lo_o likewise, so an MFHI in the same cycle as an MTHI sees the new data.
- Undefined: hi_o/lo_o are the register outputs only, and the new value is visible the cycle after the write.

Test Plan:
- DIVU a=100, b=7 at cycle t -> stall_o high t..t+32; at t+33 LO=14, HI=2, stall_o=0, busy_o=1; IDLE at t+34.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT a=0xFFFFFFFE, b=3 with MULT_CYCLES=2 -> stall high 3 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIVU a=0x1234, b=0 -> stall 1 cycle; HI=0x1234, LO=0xFFFFFFFF.
- Preload HI=LO=0xAAAA via MT; DIVU 100/7; flush at iteration 10 -> stall_o drops that cycle, state IDLE, HI=LO=0xAAAA; new MULTU 3*4 afterwards -> LO=12, HI=0.
- MTLO 0x55 on the DIV completion edge -> LO=0x55, HI=remainder. With HILO_BYPASS_EN, hi_we=1, hilo_wdata=0x77 -> hi_o=0x77 in the same cycle.
